// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences a shared datapath through
// FETCH/DECODE/EXE/MEM/WB and drives its enables and mux selects.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   opcode, funct   IR[31:26], IR[5:0]
//   zero            ALU zero flag (used by beq in EXE)
//   pc_we, ir_we, reg_we, mem_we     write enables
//   reg_dst_sel     00 rt, 01 rd, 10 $31
//   alu_srcb_sel    00 rt, 01 sext imm, 10 zext imm, 11 const 4
//   mem_to_reg_sel  00 ALU, 01 mem, 10 PC
//   pc_src_sel      00 PC+4, 01 branch, 10 jump, 11 rs
//   alu_op          000 add, 001 sub, 010 or, 011 imm<<16
//   instr_done      pulse on last cycle of each instruction
//   halted          high in S_HALT
//   state           current state (debug)
module mc_ctrl_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] alu_srcb_sel,
  output logic [1:0] mem_to_reg_sel,
  output logic [1:0] pc_src_sel,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;

  state_t cur, nxt;

  logic is_r, is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, legal;

  assign is_r    = (opcode == OP_R);
  assign is_addu = is_r && (funct == F_ADDU);
  assign is_subu = is_r && (funct == F_SUBU);
  assign is_jr   = is_r && (funct == F_JR);
  assign is_ori  = (opcode == OP_ORI);
  assign is_lui  = (opcode == OP_LUI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);
  assign legal   = is_addu | is_subu | is_jr
                 | is_ori  | is_lui  | is_lw
                 | is_sw   | is_beq  | is_j
                 | is_jal;

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        if (!legal)
          nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        else if (is_j || is_jal || is_jr)
          nxt = S_FETCH;
        else
          nxt = S_EXE;
      end
      S_EXE: begin
        if (is_lw || is_sw)  nxt = S_MEM;
        else if (is_beq)     nxt = S_FETCH;
        else if (legal)      nxt = S_WB;
        else                 nxt = S_FETCH;
      end
      S_MEM:   nxt = is_lw ? S_WB : S_FETCH;
      S_WB:    nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_we          = 1'b0;
    ir_we          = 1'b0;
    reg_we         = 1'b0;
    mem_we         = 1'b0;
    reg_dst_sel    = 2'b00;
    alu_srcb_sel   = 2'b00;
    mem_to_reg_sel = 2'b00;
    pc_src_sel     = 2'b00;
    alu_op         = 3'b000;
    instr_done     = 1'b0;
    halted         = 1'b0;
    unique case (cur)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_j: begin
            pc_we      = 1'b1;
            pc_src_sel = 2'b10;
            instr_done = 1'b1;
          end
          // $31 gets the already-incremented PC in the same
          // cycle the PC is redirected.
          is_jal: begin
            pc_we          = 1'b1;
            pc_src_sel     = 2'b10;
            reg_we         = 1'b1;
            reg_dst_sel    = 2'b10;
            mem_to_reg_sel = 2'b10;
            instr_done     = 1'b1;
          end
          is_jr: begin
            pc_we      = 1'b1;
            pc_src_sel = 2'b11;
            instr_done = 1'b1;
          end
          !legal: instr_done = !ILLEGAL_TRAP;
          default: ;
        endcase
      end
      S_EXE: begin
        unique case (1'b1)
          is_subu: alu_op = 3'b001;
          is_ori: begin
            alu_op       = 3'b010;
            alu_srcb_sel = 2'b10;
          end
          is_lui: begin
            alu_op       = 3'b011;
            alu_srcb_sel = 2'b10;
          end
          is_lw, is_sw: alu_srcb_sel = 2'b01;
          is_beq: begin
            alu_op     = 3'b001;
            pc_src_sel = 2'b01;
            pc_we      = zero;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_we     = is_sw;
        instr_done = is_sw;
      end
      S_WB: begin
        reg_we         = 1'b1;
        instr_done     = 1'b1;
        reg_dst_sel    = is_r  ? 2'b01 : 2'b00;
        mem_to_reg_sel = is_lw ? 2'b01 : 2'b00;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
